// File: rtl/rv32i_decode_execute.sv
// rtl/rv32i_decode_execute.sv - RV32I decode, control generation, ALU and branch compare
module rv32i_decode_execute #(
  parameter int                DWIDTH     = 32,
  parameter int                AWIDTH     = 32,
  parameter int                REGISTERED = 0,
  parameter logic [AWIDTH-1:0] RESET_PC   = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       insn_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] rs1data_i,
  input  logic [DWIDTH-1:0] rs2data_i,
  output logic [AWIDTH-1:0] pc_o,
  output logic [31:0]       insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
  output logic [4:0]        shamt_o,
  output logic [DWIDTH-1:0] imm_o,
  output logic              pcsel_o,
  output logic              immsel_o,
  output logic              regwren_o,
  output logic              rs1sel_o,
  output logic              rs2sel_o,
  output logic              memren_o,
  output logic              memwren_o,
  output logic [1:0]        wbsel_o,
  output logic [3:0]        alusel_o,
  output logic [DWIDTH-1:0] res_o,
  output logic              brtaken_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [31:0]       insn_q;
  logic [AWIDTH-1:0] pc_q;
  logic [31:0]       insn;
  logic [AWIDTH-1:0] pc;
  logic [31:0]       imm32;
  logic              known_op;
  logic              opa_pc;
  logic [DWIDTH-1:0] op_a;
  logic [DWIDTH-1:0] op_b;
  logic [DWIDTH-1:0] alu;
  logic              cmp_true;

  // Optional capture stage; reset loads a NOP so downstream sees a harmless instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      insn_q <= 32'h0000_0013;
      pc_q   <= RESET_PC;
    end else begin
      insn_q <= insn_i;
      pc_q   <= pc_i;
    end
  end

  assign insn = (REGISTERED != 0) ? insn_q : insn_i;
  assign pc   = (REGISTERED != 0) ? pc_q   : pc_i;

  assign insn_o   = insn;
  assign pc_o     = pc;
  assign opcode_o = insn[6:0];
  assign rd_o     = insn[11:7];
  assign funct3_o = insn[14:12];
  assign rs1_o    = insn[19:15];
  assign rs2_o    = insn[24:20];
  assign funct7_o = insn[31:25];
  assign shamt_o  = insn[24:20];

  // Immediate extraction by instruction format.
  always_comb begin
    imm32 = 32'd0;
    case (insn[6:0])
      OP_IALU, OP_LOAD, OP_JALR: imm32 = {{20{insn[31]}}, insn[31:20]};
      OP_STORE:                  imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      OP_BRANCH:                 imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      OP_LUI, OP_AUIPC:          imm32 = {insn[31:12], 12'd0};
      OP_JAL:                    imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default:                   imm32 = 32'd0;
    endcase
  end

  assign imm_o = DWIDTH'($signed(imm32));

  // Control decode: per-opcode datapath enables and ALU operation.
  always_comb begin
    pcsel_o   = 1'b0;
    immsel_o  = 1'b0;
    regwren_o = 1'b0;
    rs1sel_o  = 1'b0;
    rs2sel_o  = 1'b0;
    memren_o  = 1'b0;
    memwren_o = 1'b0;
    wbsel_o   = 2'd0;
    alusel_o  = ALU_ADD;
    known_op  = 1'b1;
    opa_pc    = 1'b0;
    case (insn[6:0])
      OP_R, OP_IALU: begin
        regwren_o = 1'b1;
        rs1sel_o  = 1'b1;
        rs2sel_o  = (insn[6:0] == OP_R);
        immsel_o  = (insn[6:0] == OP_IALU);
        case (insn[14:12])
          3'b000:  alusel_o = (insn[6:0] == OP_R && insn[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  alusel_o = ALU_SLL;
          3'b010:  alusel_o = ALU_SLT;
          3'b011:  alusel_o = ALU_SLTU;
          3'b100:  alusel_o = ALU_XOR;
          3'b101:  alusel_o = insn[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alusel_o = ALU_OR;
          default: alusel_o = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        regwren_o = 1'b1;
        rs1sel_o  = 1'b1;
        immsel_o  = 1'b1;
        memren_o  = 1'b1;
        wbsel_o   = 2'd1;
      end
      OP_STORE: begin
        rs1sel_o  = 1'b1;
        rs2sel_o  = 1'b1;
        immsel_o  = 1'b1;
        memwren_o = 1'b1;
      end
      OP_BRANCH: begin
        pcsel_o  = 1'b1;
        rs1sel_o = 1'b1;
        rs2sel_o = 1'b1;
        immsel_o = 1'b1;
        opa_pc   = 1'b1;
      end
      OP_JAL: begin
        pcsel_o   = 1'b1;
        regwren_o = 1'b1;
        immsel_o  = 1'b1;
        wbsel_o   = 2'd2;
        opa_pc    = 1'b1;
      end
      OP_JALR: begin
        pcsel_o   = 1'b1;
        regwren_o = 1'b1;
        rs1sel_o  = 1'b1;
        immsel_o  = 1'b1;
        wbsel_o   = 2'd2;
      end
      OP_LUI: begin
        regwren_o = 1'b1;
        immsel_o  = 1'b1;
        wbsel_o   = 2'd3;
      end
      OP_AUIPC: begin
        regwren_o = 1'b1;
        immsel_o  = 1'b1;
        opa_pc    = 1'b1;
      end
      default: known_op = 1'b0;
    endcase
  end

  assign op_a = opa_pc ? DWIDTH'(pc) : rs1data_i;
  assign op_b = immsel_o ? imm_o : rs2data_i;

  // ALU; shifts honour only the low five bits of operand B.
  always_comb begin
    alu = '0;
    case (alusel_o)
      ALU_ADD:  alu = op_a + op_b;
      ALU_SUB:  alu = op_a - op_b;
      ALU_SLL:  alu = op_a << op_b[4:0];
      ALU_SLT:  alu = {{(DWIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu = {{(DWIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu = op_a ^ op_b;
      ALU_SRL:  alu = op_a >> op_b[4:0];
      ALU_SRA:  alu = $signed(op_a) >>> op_b[4:0];
      ALU_OR:   alu = op_a | op_b;
      ALU_AND:  alu = op_a & op_b;
      default:  alu = '0;
    endcase
  end

  // Branch comparison works on the register operands, independent of the target adder.
  always_comb begin
    cmp_true = 1'b0;
    case (insn[14:12])
      3'b000:  cmp_true = (rs1data_i == rs2data_i);
      3'b001:  cmp_true = (rs1data_i != rs2data_i);
      3'b100:  cmp_true = ($signed(rs1data_i) <  $signed(rs2data_i));
      3'b101:  cmp_true = ($signed(rs1data_i) >= $signed(rs2data_i));
      3'b110:  cmp_true = (rs1data_i <  rs2data_i);
      3'b111:  cmp_true = (rs1data_i >= rs2data_i);
      default: cmp_true = 1'b0;
    endcase
  end

  // Result and taken flag: LUI passes imm, JALR clears bit 0, unsupported opcodes give 0.
  always_comb begin
    res_o     = '0;
    brtaken_o = 1'b0;
    if (known_op) begin
      res_o = alu;
    end
    case (insn[6:0])
      OP_LUI:          res_o = imm_o;
      OP_JALR:         res_o = {alu[DWIDTH-1:1], 1'b0};
      default:         ;
    endcase
    case (insn[6:0])
      OP_BRANCH:       brtaken_o = cmp_true;
      OP_JAL, OP_JALR: brtaken_o = 1'b1;
      default:         brtaken_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// tb/tb_rv32i_decode_execute.sv - directed self-checking bench for rv32i_decode_execute
module tb_rv32i_decode_execute;

  logic        clk;
  logic        rst;
  logic [31:0] insn;
  logic [31:0] pc;
  logic [31:0] rs1data;
  logic [31:0] rs2data;

  logic [31:0] c_pc, c_insn, c_imm, c_res;
  logic [6:0]  c_opcode, c_funct7;
  logic [4:0]  c_rd, c_rs1, c_rs2, c_shamt;
  logic [2:0]  c_funct3;
  logic        c_pcsel, c_immsel, c_regwren, c_rs1sel, c_rs2sel, c_memren, c_memwren, c_brtaken;
  logic [1:0]  c_wbsel;
  logic [3:0]  c_alusel;

  logic [31:0] r_pc, r_insn, r_imm, r_res;
  logic [6:0]  r_opcode, r_funct7;
  logic [4:0]  r_rd, r_rs1, r_rs2, r_shamt;
  logic [2:0]  r_funct3;
  logic        r_pcsel, r_immsel, r_regwren, r_rs1sel, r_rs2sel, r_memren, r_memwren, r_brtaken;
  logic [1:0]  r_wbsel;
  logic [3:0]  r_alusel;

  int n_assert = 0;
  int n_fail   = 0;

  rv32i_decode_execute #(.REGISTERED(0)) u_comb (
    .clk(clk), .rst(rst), .insn_i(insn), .pc_i(pc), .rs1data_i(rs1data), .rs2data_i(rs2data),
    .pc_o(c_pc), .insn_o(c_insn), .opcode_o(c_opcode), .rd_o(c_rd), .funct3_o(c_funct3),
    .rs1_o(c_rs1), .rs2_o(c_rs2), .funct7_o(c_funct7), .shamt_o(c_shamt), .imm_o(c_imm),
    .pcsel_o(c_pcsel), .immsel_o(c_immsel), .regwren_o(c_regwren), .rs1sel_o(c_rs1sel),
    .rs2sel_o(c_rs2sel), .memren_o(c_memren), .memwren_o(c_memwren), .wbsel_o(c_wbsel),
    .alusel_o(c_alusel), .res_o(c_res), .brtaken_o(c_brtaken)
  );

  rv32i_decode_execute #(.REGISTERED(1)) u_reg (
    .clk(clk), .rst(rst), .insn_i(insn), .pc_i(pc), .rs1data_i(rs1data), .rs2data_i(rs2data),
    .pc_o(r_pc), .insn_o(r_insn), .opcode_o(r_opcode), .rd_o(r_rd), .funct3_o(r_funct3),
    .rs1_o(r_rs1), .rs2_o(r_rs2), .funct7_o(r_funct7), .shamt_o(r_shamt), .imm_o(r_imm),
    .pcsel_o(r_pcsel), .immsel_o(r_immsel), .regwren_o(r_regwren), .rs1sel_o(r_rs1sel),
    .rs2sel_o(r_rs2sel), .memren_o(r_memren), .memwren_o(r_memwren), .wbsel_o(r_wbsel),
    .alusel_o(r_alusel), .res_o(r_res), .brtaken_o(r_brtaken)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    insn    = i;
    pc      = p;
    rs1data = a;
    rs2data = b;
    #1;
  endtask

  // Directed sequence: registered-path reset and latency first, then combinational decode vectors
  initial begin
    rst     = 1'b1;
    insn    = 32'h0050_0093;
    pc      = 32'h0000_0200;
    rs1data = 32'h0000_0055;
    rs2data = 32'h0;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reg_rst_insn",    r_insn,    32'h0000_0013);
    chk("reg_rst_pc",      r_pc,      32'h0100_0000);
    chk("reg_rst_regwren", r_regwren, 1'b1);
    chk("reg_rst_rd",      r_rd,      5'd0);
    chk("reg_rst_res",     r_res,     32'h0000_0055);

    rst     = 1'b0;
    rs1data = 32'h0;
    #1;
    chk("reg_pre_insn", r_insn, 32'h0000_0013);
    chk("reg_pre_res",  r_res,  32'h0);
    @(posedge clk);
    #1;
    chk("reg_insn", r_insn, 32'h0050_0093);
    chk("reg_pc",   r_pc,   32'h0000_0200);
    chk("reg_rd",   r_rd,   5'd1);
    chk("reg_imm",  r_imm,  32'd5);
    chk("reg_res",  r_res,  32'd5);

    drive(32'h0050_0093, 32'h0, 32'h0, 32'h0);
    chk("addi_rd",      c_rd,      5'd1);
    chk("addi_imm",     c_imm,     32'd5);
    chk("addi_res",     c_res,     32'd5);
    chk("addi_regwren", c_regwren, 1'b1);
    chk("addi_wbsel",   c_wbsel,   2'd0);
    chk("addi_immsel",  c_immsel,  1'b1);
    chk("addi_alusel",  c_alusel,  4'd0);

    drive(32'hFFF0_0093, 32'h0, 32'h0, 32'h0);
    chk("addi_neg_imm", c_imm, 32'hFFFF_FFFF);
    chk("addi_neg_res", c_res, 32'hFFFF_FFFF);

    drive(32'h4020_8133, 32'h0, 32'd10, 32'd3);
    chk("sub_alusel", c_alusel, 4'd1);
    chk("sub_res",    c_res,    32'd7);
    chk("sub_rs2sel", c_rs2sel, 1'b1);
    chk("sub_rd",     c_rd,     5'd2);
    chk("sub_imm",    c_imm,    32'd0);
    drive(32'h4020_8133, 32'h0, 32'd0, 32'd1);
    chk("sub_wrap", c_res, 32'hFFFF_FFFF);

    drive(32'h0020_A0B3, 32'h0, 32'hFFFF_FFFF, 32'd1);
    chk("slt_res", c_res, 32'd1);
    drive(32'h0020_B0B3, 32'h0, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_res", c_res, 32'd0);

    drive(32'h0020_8463, 32'h0100_0010, 32'd7, 32'd7);
    chk("beq_res",     c_res,     32'h0100_0018);
    chk("beq_imm",     c_imm,     32'd8);
    chk("beq_taken",   c_brtaken, 1'b1);
    chk("beq_pcsel",   c_pcsel,   1'b1);
    chk("beq_regwren", c_regwren, 1'b0);
    drive(32'h0020_8463, 32'h0100_0010, 32'd7, 32'd8);
    chk("beq_not_taken", c_brtaken, 1'b0);

    drive(32'h0020_C463, 32'h0, 32'hFFFF_FFFF, 32'd1);
    chk("blt_signed", c_brtaken, 1'b1);
    drive(32'h0020_E463, 32'h0, 32'hFFFF_FFFF, 32'd1);
    chk("bltu_unsigned", c_brtaken, 1'b0);
    drive(32'h0020_A463, 32'h0, 32'd5, 32'd5);
    chk("br_f3_010", c_brtaken, 1'b0);

    drive(32'h0020_A223, 32'h0, 32'h0100_0100, 32'h0);
    chk("sw_res",     c_res,     32'h0100_0104);
    chk("sw_imm",     c_imm,     32'd4);
    chk("sw_memwren", c_memwren, 1'b1);
    chk("sw_regwren", c_regwren, 1'b0);

    drive(32'h1234_50B7, 32'h0, 32'hAAAA_AAAA, 32'h0);
    chk("lui_imm",   c_imm,   32'h1234_5000);
    chk("lui_res",   c_res,   32'h1234_5000);
    chk("lui_wbsel", c_wbsel, 2'd3);

    drive(32'h0000_1097, 32'h0000_1000, 32'h0, 32'h0);
    chk("auipc_res", c_res, 32'h0000_2000);

    drive(32'h0000_8067, 32'h0, 32'h0100_0123, 32'h0);
    chk("jalr_res",   c_res,     32'h0100_0122);
    chk("jalr_taken", c_brtaken, 1'b1);
    chk("jalr_wbsel", c_wbsel,   2'd2);

    drive(32'h0080_00EF, 32'h0000_0100, 32'h0, 32'h0);
    chk("jal_res",   c_res,     32'h0000_0108);
    chk("jal_taken", c_brtaken, 1'b1);
    chk("jal_wbsel", c_wbsel,   2'd2);

    drive(32'h4020_D093, 32'h0, 32'hFFFF_FFF0, 32'h0);
    chk("srai_res",    c_res,    32'hFFFF_FFFC);
    chk("srai_alusel", c_alusel, 4'd7);
    chk("srai_shamt",  c_shamt,  5'd2);

    drive(32'h0000_0073, 32'h0000_0100, 32'h1234_5678, 32'h1);
    chk("sys_res",     c_res,     32'h0);
    chk("sys_regwren", c_regwren, 1'b0);
    chk("sys_taken",   c_brtaken, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
